// File: rtl/nios2_mul_sequencer.sv
// nios2_mul_sequencer
//
// Multi-cycle controller that computes full 32x32 products for MUL, MULXUU,
// MULXSU and MULXSS by time-sharing one external registered 16x16 unsigned
// multiplier cell. The four partial products LL, LH, HL, HH are issued back
// to back, accumulated into a 64-bit sum as they return, the signed high-word
// correction is applied, and the 32-bit result is returned.
//
// Parameters:
//   HALF_W   half-operand width (operands and products are 2*HALF_W bits)
//   MUL_LAT  cycles from a mul_en issue to the matching valid mul_p
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation request handshake
//   op                  00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   src1, src2          operands A and B
//   abort               pipeline flush, cancels the operation in flight
//   out_valid/out_ready result handshake
//   result              low word (MUL) or corrected high word
//   mul_en, mul_a/b     issue strobe and operands to the multiplier cell
//   mul_p               multiplier product, valid MUL_LAT cycles after issue
//   dbg_state           current FSM state (IDLE=0 ISSUE=1 DRAIN=2 CORR=3 DONE=4)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE. out_valid, once raised, holds together
// with a stable result until out_ready is seen (or abort/reset).
//
// Optional feature macro: NIOS2_MUL_LOW_SHORTCUT_EN. When defined, MUL skips
// the HH partial product and the CORR state (low word does not need either).

module nios2_mul_sequencer #(
  parameter int HALF_W  = 16,
  parameter int MUL_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic [2*HALF_W-1:0] src1,
  input  logic [2*HALF_W-1:0] src2,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] result,
  output logic                mul_en,
  output logic [HALF_W-1:0]   mul_a,
  output logic [HALF_W-1:0]   mul_b,
  input  logic [2*HALF_W-1:0] mul_p,
  output logic [2:0]          dbg_state
);

  localparam int W  = 2 * HALF_W;
  localparam int AW = 4 * HALF_W;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_CORR  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [W-1:0]        result_q;
  logic                mul_en_q;
  logic [HALF_W-1:0]   mul_a_q;
  logic [HALF_W-1:0]   mul_b_q;
  logic [1:0]          op_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [1:0]          iss_idx_q;
  logic [AW-1:0]       acc_q;
  logic [2:0]          ret_cnt_q;
  // Delayed copy of the issue strobe and index; the tail marks which partial
  // product is on mul_p this cycle.
  logic [MUL_LAT-1:0]  ret_v_q;
  logic [1:0]          ret_idx_q [MUL_LAT];

  // MUL-only shortcut: three partial products, no correction state.
  logic short_mul;
`ifdef NIOS2_MUL_LOW_SHORTCUT_EN
  assign short_mul = (op_q == OP_MUL);
`else
  assign short_mul = 1'b0;
`endif

  logic [1:0] last_idx;
  logic [2:0] n_iss;
  logic [1:0] nxt_idx;
  assign last_idx = short_mul ? 2'd2 : 2'd3;
  assign n_iss    = short_mul ? 3'd3 : 3'd4;
  assign nxt_idx  = iss_idx_q + 2'd1;

  function automatic logic [HALF_W-1:0] half_sel(input logic [W-1:0] v, input logic hi);
    return hi ? v[W-1:HALF_W] : v[HALF_W-1:0];
  endfunction

  // Accumulator update for the returning partial product.
  logic [AW-1:0] prod_ext;
  logic [AW-1:0] acc_d;
  always_comb begin
    prod_ext = {{(AW-W){1'b0}}, mul_p};
    case (ret_idx_q[MUL_LAT-1])
      2'd0:       acc_d = acc_q + prod_ext;
      2'd1, 2'd2: acc_d = acc_q + (prod_ext << HALF_W);
      default:    acc_d = acc_q + (prod_ext << (2 * HALF_W));
    endcase
  end

  // Signed correction of the unsigned high word, modulo 2^W.
  logic [W-1:0] hi_raw;
  logic [W-1:0] corr_a;
  logic [W-1:0] corr_b;
  logic [W-1:0] result_d;
  always_comb begin
    hi_raw   = acc_q[AW-1:W];
    corr_a   = a_q[W-1] ? b_q : '0;
    corr_b   = b_q[W-1] ? a_q : '0;
    result_d = hi_raw;
    case (op_q)
      OP_MUL:    result_d = acc_q[W-1:0];
      OP_MULXSS: result_d = hi_raw - corr_a - corr_b;
      OP_MULXSU: result_d = hi_raw - corr_a;
      default:   result_d = hi_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      iss_idx_q   <= '0;
      acc_q       <= '0;
      ret_cnt_q   <= '0;
      ret_v_q     <= '0;
      for (int i = 0; i < MUL_LAT; i++) ret_idx_q[i] <= '0;
    end else begin
      // Return pipeline tracks issues; later assignments below may clear it.
      ret_v_q[0]   <= mul_en_q;
      ret_idx_q[0] <= iss_idx_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        ret_v_q[i]   <= ret_v_q[i-1];
        ret_idx_q[i] <= ret_idx_q[i-1];
      end
      if (ret_v_q[MUL_LAT-1]) begin
        acc_q     <= acc_d;
        ret_cnt_q <= ret_cnt_q + 3'd1;
      end

      if (abort && state_q != S_IDLE) begin
        // Drop everything in flight, including products still returning.
        state_q     <= S_IDLE;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
        mul_en_q    <= 1'b0;
        mul_a_q     <= '0;
        mul_b_q     <= '0;
        ret_v_q     <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (in_valid) begin
              state_q    <= S_ISSUE;
              in_ready_q <= 1'b0;
              op_q       <= op;
              a_q        <= src1;
              b_q        <= src2;
              acc_q      <= '0;
              ret_cnt_q  <= '0;
              iss_idx_q  <= 2'd0;
              mul_en_q   <= 1'b1;
              mul_a_q    <= half_sel(src1, 1'b0);
              mul_b_q    <= half_sel(src2, 1'b0);
            end
          end
          S_ISSUE: begin
            if (iss_idx_q == last_idx) begin
              state_q  <= S_DRAIN;
              mul_en_q <= 1'b0;
              mul_a_q  <= '0;
              mul_b_q  <= '0;
            end else begin
              // idx bit 1 selects the A half, bit 0 the B half: LL, LH, HL, HH.
              iss_idx_q <= nxt_idx;
              mul_a_q   <= half_sel(a_q, nxt_idx[1]);
              mul_b_q   <= half_sel(b_q, nxt_idx[0]);
            end
          end
          S_DRAIN: begin
            // Leave only once every issued product has been summed.
            if (ret_cnt_q == n_iss) begin
              if (short_mul) begin
                state_q     <= S_DONE;
                result_q    <= result_d;
                out_valid_q <= 1'b1;
              end else begin
                state_q <= S_CORR;
              end
            end
          end
          S_CORR: begin
            state_q     <= S_DONE;
            result_q    <= result_d;
            out_valid_q <= 1'b1;
          end
          S_DONE: begin
            if (out_ready) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end
          end
          default: begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mul_en_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign mul_en    = mul_en_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign dbg_state = state_q;

endmodule
